e_slot_pool: RTL

E_SLOT_POOL -- requirements
Module: e_slot_pool

---
 rtl/e_slot_pool_if.sv | 50 +++++
 rtl/e_slot_pool.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/e_slot_pool_if.sv
// Slot pool handshake bundle: allocation offer, release request,
// flush request and the registered pool status outputs.
interface e_slot_pool_if #(
   parameter int W = 4
);
   localparam int CW = $clog2(W + 1);

   logic          alloc_vld_o;
   logic          alloc_rdy_i;
   logic [W-1:0]  alloc_o;
   logic          rel_vld_i;
   logic [W-1:0]  rel_i;
   logic          flush_i;
   logic [W-1:0]  occ_o;
   logic [CW-1:0] cnt_o;
   logic          full_o;
   logic          empty_o;
   logic          busy_o;
   logic          rel_err_o;

   modport slave (
      output alloc_vld_o,
      output alloc_o,
      output occ_o,
      output cnt_o,
      output full_o,
      output empty_o,
      output busy_o,
      output rel_err_o,
      input  alloc_rdy_i,
      input  rel_vld_i,
      input  rel_i,
      input  flush_i
   );

   modport master (
      input  alloc_vld_o,
      input  alloc_o,
      input  occ_o,
      input  cnt_o,
      input  full_o,
      input  empty_o,
      input  busy_o,
      input  rel_err_o,
      output alloc_rdy_i,
      output rel_vld_i,
      output rel_i,
      output flush_i
   );
endinterface

// File: rtl/e_slot_pool.sv
// W-slot allocator: first-fit or next-fit offer, checked one-hot release,
// and a flush that frees one slot per cycle starting from bit W-1.
module e_slot_pool #(
   parameter int W        = 4,
   parameter int NEXT_FIT = 0
) (
   input  logic         clk,
   input  logic         arst,
   e_slot_pool_if.slave bus
);
   localparam int CW = $clog2(W + 1);
   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [W-1:0] TOP = {1'b1, {(W-1){1'b0}}};

   if (W < 2 || W > 8) begin : g_bad_w
      $error("e_slot_pool: W=%0d outside legal range 2..8", W);
   end

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t        state;
   logic [W-1:0]  occ;
   logic [W-1:0]  occ_nx;
   logic [W-1:0]  offer_vec;
   logic [CW-1:0] cnt;
   logic [CW-1:0] fcnt;
   logic          full;
   logic          empty;
   logic          busy;
   logic          rel_err;
   logic          ptr_vld;
   logic [IW-1:0] ptr_idx;

   logic          hit_any;
   logic          hit_lo;
   logic [IW-1:0] idx_any;
   logic [IW-1:0] idx_lo;
   logic [IW-1:0] pick;
   logic          offer;
   logic          gnt;
   logic          run_rel;
   logic          onehot;
   logic          rel_ok;
   logic          rel_bad;

   function automatic logic [CW-1:0] popcnt(input logic [W-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // Ascending scan: the last hit is the free slot nearest bit W-1.
   // hit_lo restricts to slots after the last grant (next-fit only).
   always_comb begin
      hit_any = 1'b0;
      hit_lo  = 1'b0;
      idx_any = '0;
      idx_lo  = '0;
      for (int i = 0; i < W; i++) begin
         if (!occ[i]) begin
            hit_any = 1'b1;
            idx_any = IW'(i);
            if (NEXT_FIT != 0 && ptr_vld && i < int'(ptr_idx)) begin
               hit_lo = 1'b1;
               idx_lo = IW'(i);
            end
         end
      end
   end

   assign pick      = hit_lo ? idx_lo : idx_any;
   assign offer     = (state == S_RUN) && hit_any;
   assign offer_vec = offer ? (W'(1) << pick) : '0;
   assign gnt       = offer && bus.alloc_rdy_i;

   assign run_rel = (state == S_RUN) && bus.rel_vld_i && !bus.flush_i;
   assign onehot  = (bus.rel_i != '0) &&
                    ((bus.rel_i & (bus.rel_i - 1'b1)) == '0);
   assign rel_ok  = run_rel && onehot && |(bus.rel_i & occ);
   assign rel_bad = run_rel && !(onehot && |(bus.rel_i & occ));

   always_comb begin
      occ_nx = occ;
      unique case (state)
         S_RUN: begin
            if (gnt) begin
               occ_nx = occ_nx | offer_vec;
            end
            if (rel_ok) begin
               occ_nx = occ_nx & ~bus.rel_i;
            end
            // Flush entry already frees the first slot.
            if (bus.flush_i) begin
               occ_nx = occ_nx & ~TOP;
            end
         end
         S_FLUSH: occ_nx = occ & ~(TOP >> fcnt);
         default: occ_nx = occ;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= S_INIT;
         occ     <= '0;
         cnt     <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         busy    <= 1'b1;
         rel_err <= 1'b0;
         ptr_vld <= 1'b0;
         ptr_idx <= '0;
         fcnt    <= '0;
      end else begin
         rel_err <= 1'b0;
         unique case (state)
            S_INIT: begin
               state <= S_RUN;
               busy  <= 1'b0;
            end
            S_RUN: begin
               if (bus.flush_i) begin
                  state   <= S_FLUSH;
                  busy    <= 1'b1;
                  ptr_vld <= 1'b0;
                  fcnt    <= CW'(1);
               end else begin
                  rel_err <= rel_bad;
                  if (gnt) begin
                     ptr_vld <= 1'b1;
                     ptr_idx <= pick;
                  end
               end
            end
            S_FLUSH: begin
               if (fcnt == CW'(W)) begin
                  state <= S_RUN;
                  busy  <= 1'b0;
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            default: begin
               state <= S_INIT;
               busy  <= 1'b1;
            end
         endcase
         occ   <= occ_nx;
         cnt   <= popcnt(occ_nx);
         full  <= &occ_nx;
         empty <= ~|occ_nx;
      end
   end

   assign bus.alloc_vld_o = offer;
   assign bus.alloc_o     = offer_vec;
   assign bus.occ_o       = occ;
   assign bus.cnt_o       = cnt;
   assign bus.full_o      = full;
   assign bus.empty_o     = empty;
   assign bus.busy_o      = busy;
   assign bus.rel_err_o   = rel_err;
endmodule
